// File: rtl/mem_lsu_if.sv
// Word-wide data bus between the memory-stage load/store unit (master) and memory (slave).
interface mem_lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// M-stage load/store unit: lane steering, load extension, misalign detection, bus wait stalls.
// Optional bus timeout abort is built only when MEM_LSU_TIMEOUT_EN is defined.
module mem_lsu
`ifdef MEM_LSU_TIMEOUT_EN
    #(parameter int unsigned TIMEOUT_CYCLES = 255)
`endif
(
    input  logic             clk,
    input  logic             reset,
    input  logic             memreadM,
    input  logic [1:0]       memwriteM,
    input  logic             halfM,
    input  logic             bM,
    input  logic             bunsignedM,
    input  logic [31:0]      aluoutM,
    input  logic [31:0]      writedataM,
    output logic [31:0]      readdataM,
    output logic             stallM,
    output logic             misalignM,
    output logic             buserrM,
    mem_lsu_if.master        bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_next;
    logic        store, access, misaligned, issue, timeout_hit;
    logic [3:0]  be_lane;
    logic [31:0] wdata_lane, load_ext;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Access shape captured at issue, used to extend the returned word
    logic [1:0]  acc_lo;
    logic        acc_b, acc_h, acc_u, acc_st;

    assign store      = (memwriteM != 2'b00);
    assign access     = memreadM | store;
    assign misaligned = (halfM & ~bM & aluoutM[0]) | (~halfM & ~bM & (aluoutM[1:0] != 2'b00));
    assign issue      = (state == IDLE) & access & ~misaligned;

    // NOTE: combinational outputs are gated by reset so they read 0 while reset is held,
    // even though the stalled pipeline keeps presenting its request.
    assign stallM    = ~reset & (issue | (state == BUSY));
    assign misalignM = ~reset & (state == IDLE) & access & misaligned;

    always_comb begin
        be_lane    = 4'hF;
        wdata_lane = writedataM;
        if (bM) begin
            be_lane    = 4'b0001 << aluoutM[1:0];
            wdata_lane = {4{writedataM[7:0]}};
        end else if (halfM) begin
            be_lane    = aluoutM[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{writedataM[15:0]}};
        end
    end

    always_comb begin
        byte_sel = bus.bus_rdata[{acc_lo, 3'b000} +: 8];
        half_sel = bus.bus_rdata[{acc_lo[1], 4'b0000} +: 16];
        if (acc_b)
            load_ext = {{24{~acc_u & byte_sel[7]}}, byte_sel};
        else if (acc_h)
            load_ext = {{16{~acc_u & half_sel[15]}}, half_sel};
        else
            load_ext = bus.bus_rdata;
    end

`ifdef MEM_LSU_TIMEOUT_EN
    logic [7:0] busy_cnt;

    assign timeout_hit = (state == BUSY) & ~bus.bus_ready & (busy_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt <= 8'd0;
            buserrM  <= 1'b0;
        end else begin
            buserrM <= timeout_hit;
            if (issue)
                busy_cnt <= 8'd0;
            else if (state == BUSY)
                busy_cnt <= busy_cnt + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign buserrM     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = BUSY;
            BUSY:    if (bus.bus_ready | timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'd0;
            bus.bus_be    <= 4'd0;
            bus.bus_wdata <= 32'd0;
            readdataM     <= 32'd0;
            acc_lo        <= 2'd0;
            acc_b         <= 1'b0;
            acc_h         <= 1'b0;
            acc_u         <= 1'b0;
            acc_st        <= 1'b0;
        end else if (issue) begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= store;
            bus.bus_addr  <= {aluoutM[31:2], 2'b00};
            bus.bus_be    <= be_lane;
            bus.bus_wdata <= wdata_lane;
            acc_lo        <= aluoutM[1:0];
            acc_b         <= bM;
            acc_h         <= halfM & ~bM;
            acc_u         <= bunsignedM;
            acc_st        <= store;
        end else if (state == BUSY) begin
            if (bus.bus_ready) begin
                bus.bus_req <= 1'b0;
                readdataM   <= acc_st ? 32'd0 : load_ext;
            end else if (timeout_hit) begin
                bus.bus_req <= 1'b0;
                readdataM   <= 32'd0;
            end
        end
    end
endmodule
